mfm_byte_assembler: RTL and testbench



---
 rtl/mfm_byte_assembler.sv | 150 +++++++++++++++
 tb/tb_mfm_byte_assembler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfm_byte_assembler.sv
// MFM byte assembler: strips clock bits after a sync edge and packs data bits MSB-first into bytes.
// Latency: byte valid one clock after the phase-15 strobe; a full output register drops new bytes (OVERRUN).
// Optional MFM_SYNC_REALIGN_EN: a sync edge mid-record realigns the bit phase and drops the partial byte.
module mfm_byte_assembler #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   CLK_PLL32MHZ,
    input  logic                   RESET_N,
    input  logic                   START,
    input  logic                   ABORT,
    input  logic [COUNT_WIDTH-1:0] BYTE_COUNT,
    input  logic                   BIT_VALID,
    input  logic                   BIT_IN,
    input  logic                   SYNC_WORD_DETECTED,
    output logic [7:0]             BYTE_OUT,
    output logic                   BYTE_VALID,
    input  logic                   BYTE_READY,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   OVERRUN,
    output logic [COUNT_WIDTH-1:0] BYTES_DONE
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SYNC,
        ST_ASSEMBLE,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync_d_q;
    logic [3:0]             phase_q, phase_d;
    logic [6:0]             shift_q, shift_d;
    logic [7:0]             byte_out_q, byte_out_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;
    logic [COUNT_WIDTH-1:0] bytes_done_q, bytes_done_d;

    logic                   sync_edge;
    logic                   realign;
    logic [COUNT_WIDTH-1:0] bytes_done_inc;

    assign sync_edge      = SYNC_WORD_DETECTED && !sync_d_q;
    assign bytes_done_inc = bytes_done_q + COUNT_WIDTH'(1);

`ifdef MFM_SYNC_REALIGN_EN
    assign realign = sync_edge;
`else
    assign realign = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        shift_d      = shift_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = byte_valid_q;
        done_d       = done_q;
        overrun_d    = overrun_q;
        bytes_done_d = bytes_done_q;

        if (byte_valid_q && BYTE_READY) begin
            byte_valid_d = 1'b0;
        end

        if (ABORT) begin
            state_d      = ST_IDLE;
            byte_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state_d      = ST_WAIT_SYNC;
                        done_d       = 1'b0;
                        overrun_d    = 1'b0;
                        bytes_done_d = '0;
                        phase_d      = 4'd0;
                        shift_d      = 7'd0;
                    end
                end
                // A strobe coincident with the sync edge is the mark's last bit and is dropped.
                ST_WAIT_SYNC: begin
                    if (sync_edge) begin
                        state_d = ST_ASSEMBLE;
                        phase_d = 4'd0;
                    end
                end
                ST_ASSEMBLE: begin
                    if (realign) begin
                        phase_d = 4'd0;
                        shift_d = 7'd0;
                    end else if (BIT_VALID) begin
                        phase_d = phase_q + 4'd1;
                        if (phase_q[0]) begin
                            shift_d = {shift_q[5:0], BIT_IN};
                        end
                        if (phase_q == 4'd15) begin
                            bytes_done_d = bytes_done_inc;
                            // Transfer in this cycle frees the register, so load still succeeds.
                            if (!byte_valid_q || BYTE_READY) begin
                                byte_out_d   = {shift_q, BIT_IN};
                                byte_valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                            if ((BYTE_COUNT != '0) && (bytes_done_inc == BYTE_COUNT)) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK_PLL32MHZ) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            sync_d_q     <= 1'b0;
            phase_q      <= 4'd0;
            shift_q      <= 7'd0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            bytes_done_q <= '0;
        end else begin
            state_q      <= state_d;
            sync_d_q     <= SYNC_WORD_DETECTED;
            phase_q      <= phase_d;
            shift_q      <= shift_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            bytes_done_q <= bytes_done_d;
        end
    end

    assign BYTE_OUT   = byte_out_q;
    assign BYTE_VALID = byte_valid_q;
    assign BUSY       = (state_q == ST_WAIT_SYNC) || (state_q == ST_ASSEMBLE);
    assign DONE       = done_q;
    assign OVERRUN    = overrun_q;
    assign BYTES_DONE = bytes_done_q;

endmodule

// File: tb/tb_mfm_byte_assembler.sv
// Randomized and directed stimulus for mfm_byte_assembler, checked every cycle against a record-level model.
module tb_mfm_byte_assembler;

`ifdef MFM_SYNC_REALIGN_EN
    localparam bit REALIGN = 1'b1;
`else
    localparam bit REALIGN = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_ASM  = 2;
    localparam int M_DONE = 3;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] byte_count;
    logic        bit_valid;
    logic        bit_in;
    logic        sync;
    logic        ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [15:0] bytes_done;

    mfm_byte_assembler #(.COUNT_WIDTH(16)) dut (
        .CLK_PLL32MHZ      (clk),
        .RESET_N           (rst_n),
        .START             (start),
        .ABORT             (abort),
        .BYTE_COUNT        (byte_count),
        .BIT_VALID         (bit_valid),
        .BIT_IN            (bit_in),
        .SYNC_WORD_DETECTED(sync),
        .BYTE_OUT          (byte_out),
        .BYTE_VALID        (byte_valid),
        .BYTE_READY        (ready),
        .BUSY              (busy),
        .DONE              (done),
        .OVERRUN           (overrun),
        .BYTES_DONE        (bytes_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Record-level model: strobe count since alignment, data bits accumulated by bit weight.
    int          m_state;
    bit          m_sync_d;
    int          m_k;
    bit [7:0]    m_acc;
    bit [7:0]    m_out;
    bit          m_vld;
    bit          m_done;
    bit          m_ovr;
    int unsigned m_bd;

    task automatic model_edge();
        bit edge_s;
        edge_s = sync && !m_sync_d;
        if (!rst_n) begin
            m_state = M_IDLE; m_sync_d = 0; m_k = 0; m_acc = 0; m_out = 0;
            m_vld = 0; m_done = 0; m_ovr = 0; m_bd = 0;
            return;
        end
        if (m_vld && ready) m_vld = 0;
        if (abort) begin
            m_state = M_IDLE;
            m_vld   = 0;
        end else begin
            case (m_state)
                M_IDLE, M_DONE: if (start) begin
                    m_state = M_WAIT; m_done = 0; m_ovr = 0; m_bd = 0; m_k = 0; m_acc = 0;
                end
                M_WAIT: if (edge_s) begin
                    m_state = M_ASM; m_k = 0; m_acc = 0;
                end
                M_ASM: begin
                    if (edge_s && REALIGN) begin
                        m_k = 0; m_acc = 0;
                    end else if (bit_valid) begin
                        if (m_k % 2 == 1) m_acc = m_acc | 8'(8'(bit_in) << (7 - m_k / 2));
                        if (m_k == 15) begin
                            m_bd = (m_bd + 1) % 65536;
                            if (!m_vld) begin m_out = m_acc; m_vld = 1; end
                            else m_ovr = 1;
                            if (byte_count != 0 && m_bd == byte_count) begin
                                m_state = M_DONE; m_done = 1;
                            end
                            m_acc = 0;
                        end
                        m_k = (m_k + 1) % 16;
                    end
                end
                default: m_state = M_IDLE;
            endcase
        end
        m_sync_d = sync;
    endtask

    int       vld_cycles;
    int       n_xfer;
    bit [7:0] first_xfer;
    int       ready_mode;
    bit       rand_abort;

    task automatic tick();
        if (byte_valid && ready) begin
            if (n_xfer == 0) first_xfer = byte_out;
            n_xfer++;
        end
        @(posedge clk);
        model_edge();
        #1;
        chk("byte_valid", byte_valid, m_vld);
        chk("byte_out",   byte_out,   m_out);
        chk("busy",       busy,       (m_state == M_WAIT) || (m_state == M_ASM));
        chk("done",       done,       m_done);
        chk("overrun",    overrun,    m_ovr);
        chk("bytes_done", bytes_done, m_bd);
        if (byte_valid) vld_cycles++;
    endtask

    task automatic cyc();
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = ($urandom_range(9, 0) < 7);
            default: ready = 1'b0;
        endcase
        if (rand_abort) abort = ($urandom_range(249, 0) == 0);
        tick();
    endtask

    task automatic idle(input int n);
        bit_valid = 0; sync = 0;
        repeat (n) cyc();
    endtask

    bit [7:0] tx_d[$];
    bit       tx_s[$];

    // Streams tx_d as MFM strobes; tx_s marks bytes whose final strobe carries a sync rise.
    task automatic send(input int gap, input int nst);
        int cnt;
        cnt = 0;
        for (int b = 0; b < tx_d.size(); b++) begin
            for (int p = 0; p < 16; p++) begin
                if (nst >= 0 && cnt >= nst) begin
                    bit_valid = 0; sync = 0;
                    return;
                end
                repeat ($urandom_range(gap, 0)) begin
                    bit_valid = 0; sync = 0; cyc();
                end
                bit_valid = 1;
                bit_in    = (p % 2 == 1) ? tx_d[b][7 - p / 2] : 1'($urandom_range(1, 0));
                sync      = tx_s[b] && (p == 15);
                cyc();
                cnt++;
            end
        end
        bit_valid = 0; sync = 0;
    endtask

    task automatic start_rec(input logic [15:0] cnt);
        byte_count = cnt; start = 1; cyc(); start = 0;
    endtask

    task automatic sync_pulse(input bit coincident);
        sync = 1; bit_valid = coincident; bit_in = 1'($urandom_range(1, 0));
        cyc();
        sync = 0; bit_valid = 0;
    endtask

    task automatic abort_pulse();
        abort = 1; cyc(); abort = 0;
    endtask

    task automatic load1(input bit [7:0] v, input bit s);
        tx_d.push_back(v); tx_s.push_back(s);
    endtask

    initial begin
        rst_n = 0; start = 0; abort = 0; byte_count = 0; bit_valid = 0; bit_in = 0;
        sync = 0; ready = 1; ready_mode = 0; rand_abort = 0;
        vld_cycles = 0; n_xfer = 0; first_xfer = 0;
        m_state = M_IDLE; m_sync_d = 0; m_k = 0; m_acc = 0; m_out = 0;
        m_vld = 0; m_done = 0; m_ovr = 0; m_bd = 0;

        // Reset state
        cyc(); cyc();
        chk("rst_byte_out", byte_out, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1;
        idle(2);

        // Single byte 0x4E, one-cycle valid
        start_rec(16'd0);
        sync_pulse(0);
        tx_d.delete(); tx_s.delete(); load1(8'h4E, 0);
        vld_cycles = 0;
        send(1, -1);
        idle(4);
        chk("t4e_byte", byte_out, 8'h4E);
        chk("t4e_vld_cycles", vld_cycles, 1);
        chk("t4e_bytes_done", bytes_done, 1);
        abort_pulse();

        // Counted record of three bytes, then extra strobes ignored
        start_rec(16'd3);
        sync_pulse(0);
        tx_d.delete(); tx_s.delete(); load1(8'hFE, 0); load1(8'h00, 0); load1(8'h01, 0);
        n_xfer = 0;
        send(0, -1);
        idle(2);
        chk("cnt_done", done, 1'b1);
        chk("cnt_busy", busy, 1'b0);
        tx_d.delete(); tx_s.delete(); load1(8'h55, 0);
        send(0, -1);
        idle(2);
        chk("cnt_bytes_done", bytes_done, 3);
        chk("cnt_xfers", n_xfer, 3);
        chk("cnt_last", byte_out, 8'h01);

        // Overrun with ready held low
        ready_mode = 2;
        start_rec(16'd0);
        sync_pulse(0);
        tx_d.delete(); tx_s.delete(); load1(8'h12, 0); load1(8'h34, 0);
        send(1, -1);
        idle(2);
        chk("ovr_byte", byte_out, 8'h12);
        chk("ovr_flag", overrun, 1'b1);
        chk("ovr_bytes_done", bytes_done, 2);
        ready_mode = 0; n_xfer = 0;
        idle(3);
        chk("ovr_xfers", n_xfer, 1);
        chk("ovr_xfer_val", first_xfer, 8'h12);
        abort_pulse();

        // Strobe coincident with the sync edge is not counted
        start_rec(16'd0);
        sync_pulse(1);
        tx_d.delete(); tx_s.delete(); load1(8'hC3, 0);
        send(0, -1);
        idle(2);
        chk("coinc_byte", byte_out, 8'hC3);
        chk("coinc_bytes_done", bytes_done, 1);
        abort_pulse();

        // Abort mid-byte while a byte is held
        ready_mode = 2;
        start_rec(16'd0);
        sync_pulse(0);
        tx_d.delete(); tx_s.delete(); load1(8'h5A, 0); load1(8'h77, 0);
        send(0, 23);
        abort_pulse();
        chk("abort_vld", byte_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        ready_mode = 0;

        // Reset mid-record
        start_rec(16'd0);
        sync_pulse(0);
        tx_d.delete(); tx_s.delete(); load1(8'h9C, 0); load1(8'h3B, 0);
        send(0, 21);
        rst_n = 0; cyc();
        chk("mrst_byte_out", byte_out, 8'h00);
        chk("mrst_vld", byte_valid, 1'b0);
        chk("mrst_bytes_done", bytes_done, 0);
        rst_n = 1;
        idle(2);

        // Repeated A1 marks
        start_rec(16'd0);
        sync_pulse(0);
        tx_d.delete(); tx_s.delete(); load1(8'hA1, 1); load1(8'hA1, 1); load1(8'hFE, 0);
        n_xfer = 0;
        send(1, -1);
        idle(3);
        chk("a1_first", first_xfer, REALIGN ? 8'hFE : 8'hA1);
        chk("a1_bytes_done", bytes_done, REALIGN ? 1 : 3);
        abort_pulse();

        // Randomized records
        rand_abort = 1; ready_mode = 1;
        for (int r = 0; r < 40; r++) begin
            start_rec(16'($urandom_range(4, 0)));
            idle($urandom_range(2, 0));
            sync_pulse(1'($urandom_range(1, 0)));
            tx_d.delete(); tx_s.delete();
            repeat ($urandom_range(6, 1)) load1(8'($urandom), ($urandom_range(9, 0) == 0));
            send(2, -1);
            idle($urandom_range(4, 0));
            if ($urandom_range(3, 0) == 0) begin
                rand_abort = 0; abort_pulse(); rand_abort = 1;
            end
        end
        rand_abort = 0; abort = 0; ready_mode = 0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
